// File: rtl/da_dct_engine.sv
// Distributed-arithmetic DCT engine: butterflies over a block of samples, then a bit-serial
// ROM-accumulate per coefficient. Optional output rounding under macro DA_DCT_ROUND_EN.
module da_dct_engine #(
  parameter  int DW    = 15,
  parameter  int NPT   = 16,
  parameter  int NCOEF = 4,
  parameter  int CW    = 15,
  parameter  int OSH   = 15,
  localparam int XW    = DW + 2,
  localparam int M     = NPT / 4,
  localparam int AW    = CW + XW,
  localparam int OW    = AW - OSH,
  localparam int IW    = $clog2(NCOEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [OW-1:0] m_data,
  output logic [IW-1:0]        m_idx,
  output logic                 m_last,
  output logic [M-1:0]         rom_addr,
  output logic [IW-1:0]        rom_k,
  input  logic signed [CW-1:0] rom_data,
  output logic                 busy
);

  // state  | meaning
  // S_LOAD | accepting samples into d[]
  // S_BFLY | one-cycle butterfly d[] -> x[]
  // S_ACC  | bit-serial accumulate, MSB first, XW cycles
  // S_OUT  | coefficient presented, waiting for m_ready
  typedef enum logic [1:0] {S_LOAD, S_BFLY, S_ACC, S_OUT} state_t;

  localparam int CNTW = $clog2(NPT);
  localparam int BW   = $clog2(XW);
  localparam int RSH  = (OSH > 0) ? OSH - 1 : 0;
  localparam logic signed [AW:0] RND = (OSH > 0) ? ({{AW{1'b0}}, 1'b1} << RSH) : '0;

  state_t state_q, state_d;

  logic [CNTW-1:0]       cnt_q;
  logic signed [DW-1:0]  d_q [NPT];
  logic signed [XW-1:0]  x_q [M];
  logic signed [XW-1:0]  x_d [M];
  logic [IW-1:0]         k_q;
  logic [BW-1:0]         bit_q;
  logic signed [AW-1:0]  acc_q, acc_d, rom_sx;
  logic signed [AW:0]    rnd_w, shf_w;
  logic signed [OW-1:0]  m_data_q, m_data_d;
  logic [IW-1:0]         m_idx_q;
  logic                  m_last_q;

  logic s_fire, m_fire, cnt_last, bit_top, bit_zero, k_last;

  assign s_fire   = s_valid & s_ready;
  assign m_fire   = m_valid & m_ready;
  assign cnt_last = (cnt_q == CNTW'(NPT - 1));
  assign bit_top  = (bit_q == BW'(XW - 1));
  assign bit_zero = (bit_q == '0);
  assign k_last   = (k_q == IW'(NCOEF - 1));

  function automatic logic signed [XW-1:0] sx(input logic signed [DW-1:0] v);
    return {{2{v[DW-1]}}, v};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: if (s_fire && cnt_last) state_d = S_BFLY;
      S_BFLY: state_d = S_ACC;
      S_ACC:  if (bit_zero) state_d = S_OUT;
      S_OUT:  if (m_fire) state_d = k_last ? S_LOAD : S_ACC;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    s_ready  = (state_q == S_LOAD);
    busy     = (state_q != S_LOAD);
    m_valid  = (state_q == S_OUT);
    m_data   = m_data_q;
    m_idx    = m_idx_q;
    m_last   = m_last_q;
    rom_addr = '0;
    rom_k    = '0;
    if (state_q == S_ACC) begin
      rom_k = k_q;
      for (int m = 0; m < M; m++) rom_addr[M-1-m] = x_q[m][bit_q];
    end
  end

  // Butterfly: only the even-symmetric/odd-antisymmetric combination needed by the ROM.
  always_comb begin
    for (int m = 0; m < M; m++) begin
      x_d[m] = sx(d_q[m]) + sx(d_q[NPT-1-m]) - (sx(d_q[NPT/2-1-m]) + sx(d_q[NPT/2+m]));
    end
  end

  // MSB carries negative weight, so its ROM term is subtracted.
  always_comb begin
    rom_sx = {{XW{rom_data[CW-1]}}, rom_data};
    if (bit_top) acc_d = -rom_sx;
    else         acc_d = (acc_q <<< 1) + rom_sx;
`ifdef DA_DCT_ROUND_EN
    rnd_w = {acc_d[AW-1], acc_d} + RND;
`else
    rnd_w = {acc_d[AW-1], acc_d};
`endif
    shf_w    = rnd_w >>> OSH;
    m_data_d = shf_w[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && s_valid) d_q[cnt_q] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      k_q      <= '0;
      bit_q    <= BW'(XW - 1);
      acc_q    <= '0;
      m_data_q <= '0;
      m_idx_q  <= '0;
      m_last_q <= 1'b0;
      for (int m = 0; m < M; m++) x_q[m] <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (s_fire) cnt_q <= cnt_last ? '0 : cnt_q + CNTW'(1);
        end
        S_BFLY: begin
          for (int m = 0; m < M; m++) x_q[m] <= x_d[m];
          k_q   <= '0;
          bit_q <= BW'(XW - 1);
          acc_q <= '0;
        end
        S_ACC: begin
          acc_q <= acc_d;
          bit_q <= bit_q - BW'(1);
          if (bit_zero) begin
            m_data_q <= m_data_d;
            m_idx_q  <= k_q;
            m_last_q <= k_last;
          end
        end
        S_OUT: begin
          if (m_fire) begin
            if (k_last) begin
              k_q <= '0;
            end else begin
              k_q   <= k_q + IW'(1);
              bit_q <= BW'(XW - 1);
              acc_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_da_dct_engine.sv
// Directed bench for da_dct_engine: three instances (NPT=16/OSH=0, NPT=16/OSH=1, NPT=8/OSH=0)
// driven one at a time through a shared stimulus/observation mux; ROM model is popcount(addr).
module tb_da_dct_engine;
  localparam int DW = 15;
  localparam int CW = 15;
  localparam int XW = DW + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 s_valid, m_ready;
  logic signed [DW-1:0] s_data;
  int                   sel;

  // instance A: NPT=16, OSH=0
  logic s_ready_a, m_valid_a, m_last_a, busy_a;
  logic signed [31:0] m_data_a;
  logic [1:0] m_idx_a, rom_k_a;
  logic [3:0] rom_addr_a;
  logic signed [CW-1:0] rom_data_a;
  // instance B: NPT=16, OSH=1
  logic s_ready_b, m_valid_b, m_last_b, busy_b;
  logic signed [30:0] m_data_b;
  logic [1:0] m_idx_b, rom_k_b;
  logic [3:0] rom_addr_b;
  logic signed [CW-1:0] rom_data_b;
  // instance C: NPT=8, OSH=0
  logic s_ready_c, m_valid_c, m_last_c, busy_c;
  logic signed [31:0] m_data_c;
  logic [1:0] m_idx_c, rom_k_c;
  logic [1:0] rom_addr_c;
  logic signed [CW-1:0] rom_data_c;

  assign rom_data_a = CW'($countones(rom_addr_a));
  assign rom_data_b = CW'($countones(rom_addr_b));
  assign rom_data_c = CW'($countones(rom_addr_c));

  da_dct_engine #(.DW(DW), .NPT(16), .NCOEF(4), .CW(CW), .OSH(0)) u_dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid & (sel == 0)), .s_ready(s_ready_a), .s_data(s_data),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_idx(m_idx_a), .m_last(m_last_a),
    .rom_addr(rom_addr_a), .rom_k(rom_k_a), .rom_data(rom_data_a), .busy(busy_a));

  da_dct_engine #(.DW(DW), .NPT(16), .NCOEF(4), .CW(CW), .OSH(1)) u_dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid & (sel == 1)), .s_ready(s_ready_b), .s_data(s_data),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_idx(m_idx_b), .m_last(m_last_b),
    .rom_addr(rom_addr_b), .rom_k(rom_k_b), .rom_data(rom_data_b), .busy(busy_b));

  da_dct_engine #(.DW(DW), .NPT(8), .NCOEF(4), .CW(CW), .OSH(0)) u_dut_c (
    .clk(clk), .rst(rst), .s_valid(s_valid & (sel == 2)), .s_ready(s_ready_c), .s_data(s_data),
    .m_valid(m_valid_c), .m_ready(m_ready), .m_data(m_data_c), .m_idx(m_idx_c), .m_last(m_last_c),
    .rom_addr(rom_addr_c), .rom_k(rom_k_c), .rom_data(rom_data_c), .busy(busy_c));

  logic   obs_valid, obs_sready, obs_last, obs_busy;
  longint obs_data;
  int     obs_idx;

  always_comb begin
    obs_valid = m_valid_a; obs_sready = s_ready_a; obs_last = m_last_a; obs_busy = busy_a;
    obs_data = m_data_a; obs_idx = int'(m_idx_a);
    case (sel)
      1: begin
        obs_valid = m_valid_b; obs_sready = s_ready_b; obs_last = m_last_b; obs_busy = busy_b;
        obs_data = m_data_b; obs_idx = int'(m_idx_b);
      end
      2: begin
        obs_valid = m_valid_c; obs_sready = s_ready_c; obs_last = m_last_c; obs_busy = busy_c;
        obs_data = m_data_c; obs_idx = int'(m_idx_c);
      end
      default: ;
    endcase
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  logic signed [DW-1:0] blk [16];
  int acc_cyc = 0;

  task automatic set_blk(input int mode, input int v0);
    for (int i = 0; i < 16; i++) blk[i] = (mode == 1) ? DW'(i) : '0;
    if (mode == 2) blk[0] = DW'(v0);
  endtask

  task automatic feed(input int npt);
    for (int i = 0; i < npt; i++) begin
      int n = 0;
      s_valid = 1'b1;
      s_data  = blk[i];
      while (!obs_sready && n < 50) begin @(posedge clk); #1; n++; end
      if (!obs_sready) check("feed_ready", 0, 1);
      @(posedge clk); #1;
    end
    acc_cyc = cyc;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic collect(input int nget, input longint expv, input string tag, input int hold_idx);
    int last_cyc = 0;
    for (int k = 0; k < nget; k++) begin
      int n = 0;
      while (!obs_valid && n < 100) begin @(posedge clk); #1; n++; end
      if (!obs_valid) begin check({tag, "_timeout"}, 0, 1); return; end
      if (k == 0) check({tag, "_lat"}, longint'(cyc - acc_cyc), XW + 1);
      else        check({tag, "_gap"}, longint'(cyc - last_cyc), XW + 1);
      last_cyc = cyc;
      check({tag, "_data"}, obs_data, expv);
      check({tag, "_idx"}, obs_idx, k);
      check({tag, "_last"}, obs_last, (k == 3) ? 1 : 0);
      if (k == hold_idx) begin
        m_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
          s_valid = (j % 2 == 0);
          s_data  = DW'(77);
          @(posedge clk); #1;
          check({tag, "_hold_valid"}, obs_valid, 1);
          check({tag, "_hold_data"}, obs_data, expv);
          check({tag, "_hold_idx"}, obs_idx, k);
          check({tag, "_hold_sready"}, obs_sready, 0);
        end
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b1;
        last_cyc = cyc;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [16:0] pat;
    logic        lo_or;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", obs_valid, 0);
    check("rst_sready", obs_sready, 1);
    check("rst_busy", obs_busy, 0);
    check("rst_data", obs_data, 0);
    check("rst_idx", obs_idx, 0);
    check("rst_last", obs_last, 0);

    set_blk(0, 0); feed(16); collect(4, 0, "zero", -1);
    check("zero_sready_after", obs_sready, 1);
    check("zero_valid_after", obs_valid, 0);

    set_blk(1, 0); feed(16); collect(4, 0, "ramp", -1);

    set_blk(2, 100); feed(16); collect(4, 100, "hold", 1);
    check("hold_sready_after", obs_sready, 1);

    set_blk(2, 100); feed(16); collect(2, 100, "prerst", -1);
    repeat (5) @(posedge clk);
    #1;
    check("prerst_busy", obs_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", obs_valid, 0);
    check("midrst_sready", obs_sready, 1);
    check("midrst_idx", obs_idx, 0);
    set_blk(2, 100); feed(16); collect(4, 100, "postrst", -1);

    sel = 1;
`ifdef DA_DCT_ROUND_EN
    set_blk(2, -3); feed(16); collect(4, -1, "osh_neg", -1);
    set_blk(2, 3);  feed(16); collect(4, 2, "osh_pos", -1);
`else
    set_blk(2, -3); feed(16); collect(4, -2, "osh_neg", -1);
    set_blk(2, 3);  feed(16); collect(4, 1, "osh_pos", -1);
`endif

    sel = 2;
    set_blk(2, 5); feed(8);
    @(posedge clk); #1;
    pat = '0; lo_or = 1'b0;
    for (int b = 0; b < XW; b++) begin
      pat   = {pat[15:0], rom_addr_c[1]};
      lo_or = lo_or | rom_addr_c[0];
      @(posedge clk); #1;
    end
    check("npt8_rom_msb", pat, 5);
    check("npt8_rom_lsb", lo_or, 0);
    collect(4, 5, "npt8", -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/da_dct_engine.md
DA_DCT_ENGINE -- requirements
Module: da_dct_engine

Interface
REQ-001 Parameters (name, default, meaning); derived widths are XW=DW+2, M=NPT/4, AW=CW+XW, OW=AW-OSH, IW=$clog2(NCOEF):
- DW, 15, input sample width, signed.
- NPT, 16, points per block; 8 or 16.
- NCOEF, 4, coefficients computed per block; at least 2.
- CW, 15, external ROM word width, signed.
- OSH, 15, arithmetic right shift applied to the accumulator at output; must be less than AW.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all flops rise-edge.
- rst, in, 1, synchronous reset, active-high.
- s_valid, in, 1, input sample valid.
- s_ready, out, 1, input sample accepted when s_valid and s_ready are both high.
- s_data, in, DW, signed sample.
- m_valid, out, 1, coefficient valid.
- m_ready, in, 1, downstream accept.
- m_data, out, OW, signed coefficient.
- m_idx, out, IW, coefficient index k.
- m_last, out, 1, high with k=NCOEF-1.
- rom_addr, out, M, DA ROM address.
- rom_k, out, IW, DA ROM bank select, equal to the current k.
- rom_data, in, CW, combinational ROM word for {rom_k, rom_addr}, used in the same cycle.
- busy, out, 1, high in any state other than LOAD.

Function
REQ-003 FSM states: LOAD, BFLY, ACC, OUT; exactly one state per cycle.
REQ-004 LOAD: s_ready=1; each transfer writes d[cnt]<=s_data and increments cnt; the transfer with cnt=NPT-1 clears cnt and enters BFLY.
REQ-005 s_ready=0 outside LOAD; s_valid is ignored there and no sample is lost or stored.
REQ-006 BFLY (1 cycle): for m=0..M-1, x_m <= d[m]+d[NPT-1-m]-(d[NPT/2-1-m]+d[NPT/2+m]), XW-bit signed, exact with no overflow; k<=0; bit<=XW-1; acc<=0; next state ACC.
REQ-007 ACC: rom_addr = {x_0[bit], x_1[bit], ..., x_{M-1}[bit]}, with x_0 as the MSB; rom_k=k.
REQ-008 ACC accumulate: at bit=XW-1, acc <= -sext(rom_data); otherwise acc <= (acc<<1)+sext(rom_data); acc is AW-bit signed; bit decrements each cycle.
REQ-009 ACC runs exactly XW cycles per coefficient; after bit=0 it enters OUT with m_valid=1.
REQ-010 OUT: m_data, m_idx and m_last are registered and held stable while m_valid=1 and m_ready=0.
REQ-011 OUT transfer (m_valid and m_ready): if k=NCOEF-1, go to LOAD, clear m_valid and clear k; otherwise k<=k+1, bit<=XW-1, acc<=0, go to ACC.
REQ-012 m_ready already high when m_valid rises: the transfer occurs on that edge, so OUT lasts 1 cycle.
REQ-013 Latency: m_valid for k=0 rises XW+1 edges after the edge accepting the last sample.
REQ-014 Throughput: XW+1 cycles per coefficient with m_ready held high; no input is accepted until the last coefficient transfers.
REQ-015 rom_addr=0 and rom_k=0 outside ACC.

Reset
REQ-016 rst=1 at a clock edge, in any state, gives: state LOAD, cnt=0, k=0, bit=XW-1, acc=0, x_m=0.
REQ-017 On the same reset edge the outputs take: m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, s_ready=1 from the next cycle.
REQ-018 Reset mid-block discards the partial block and any pending coefficient; the d[] contents are don't-care.

Configuration
REQ-019 Macro DA_DCT_ROUND_EN defined: m_data <= (acc + 2^(OSH-1)) >>> OSH, round-half-up; with OSH=0 no rounding term is added.
REQ-020 Macro DA_DCT_ROUND_EN undefined: m_data <= acc >>> OSH, truncation toward minus infinity.

Verification
Bench ROM model: rom_data = popcount(rom_addr), independent of rom_k; bench parameters OSH=0 unless stated otherwise; NPT=16, DW=15.
REQ-021 Feed 16 zero samples, m_ready=1 -> four coefficients, all m_data=0; m_idx=0..3; m_last on idx 3; m_valid spacing 18 cycles; s_ready high again after the last transfer.
REQ-022 Feed d[i]=i -> all x_m=0 -> all m_data=0. Feed d[0]=100 with all others 0 -> all four coefficients m_data=100.
REQ-023 d[0]=-3, all others 0, OSH=1 -> m_data=-1 with DA_DCT_ROUND_EN defined and -2 with it undefined. d[0]=3 gives 2 and 1 respectively.
REQ-024 Hold m_ready=0 for 10 cycles on idx 1 -> m_data and m_idx stay stable; s_valid pulses during this time are not accepted; the remaining coefficients follow correctly.
REQ-025 Assert rst during ACC of idx 2 -> next cycle m_valid=0 and s_ready=1; a fresh block with d[0]=100 yields 100 for all four coefficients.
REQ-026 NPT=8, d[0]=5, others 0 -> M=2, rom_addr MSB toggles per bit of 5, all m_data=5.
